// File: rtl/fir_filter_pkg.sv
// Shared definitions for the FIR filter family: the MAC sequencer state type
// and the full-precision result width used by the serial and parallel variants.
package fir_filter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MULT  = 2'd1,
      DRAIN = 2'd2
   } fir_state_e;

   // Sum of taps_num products of data_width x coef_width signed operands
   // never overflows this width.
   function automatic int fir_out_width(input int data_width,
                                        input int coef_width,
                                        input int taps_num);
      return data_width + coef_width + $clog2(taps_num);
   endfunction

endpackage

// File: rtl/fir_filter_mac_unit.sv
// Registered signed multiplier, clearable accumulator and final output adder
// for the time-multiplexed FIR dot product.
module fir_filter_mac_unit #(
   parameter int DataWidth = 16,
   parameter int CoefWidth = 16,
   parameter int OutWidth  = 36
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 mul_en,
   input  logic                 acc_en,
   input  logic                 out_en,
   input  logic [DataWidth-1:0] sample,
   input  logic [CoefWidth-1:0] coef,
   output logic [OutWidth-1:0]  dout
);

   localparam int ProdWidth = DataWidth + CoefWidth;

   logic signed [ProdWidth-1:0] sample_ext;
   logic signed [ProdWidth-1:0] coef_ext;
   logic signed [ProdWidth-1:0] prod;
   logic signed [OutWidth-1:0]  prod_ext;
   logic signed [OutWidth-1:0]  acc;

   assign sample_ext = {{CoefWidth{sample[DataWidth-1]}}, sample};
   assign coef_ext   = {{DataWidth{coef[CoefWidth-1]}}, coef};
   assign prod_ext   = OutWidth'(prod);

   // Multiplier and adder each terminate in a register, so they never chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod <= '0;
         acc  <= '0;
         dout <= '0;
      end else begin
         if (mul_en) begin
            prod <= sample_ext * coef_ext;
         end
         if (clr) begin
            acc <= '0;
         end else if (acc_en) begin
            acc <= acc + prod_ext;
         end
         if (out_en) begin
            dout <= acc + prod_ext;
         end
      end
   end

endmodule

// File: rtl/fir_filter_serial_mac.sv
// Serial multiply-accumulate FIR stage: snapshots the tap vector on accept and
// produces the full-precision dot product one tap per clock through one multiplier.
module fir_filter_serial_mac
   import fir_filter_pkg::*;
#(
   parameter  int DataWidth = 16,
   parameter  int CoefWidth = 16,
   parameter  int TapsNum   = 10,
   localparam int OutWidth  = fir_out_width(DataWidth, CoefWidth, TapsNum)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                ready,
   input  logic [0:TapsNum-1][DataWidth-1:0]   taps,
   input  logic [0:TapsNum-1][CoefWidth-1:0]   coefs,
   output logic                                out_valid,
   output logic [OutWidth-1:0]                 dout
);

   localparam int                KWidth = (TapsNum > 1) ? $clog2(TapsNum) : 1;
   localparam logic [KWidth-1:0] KLast  = KWidth'(TapsNum - 1);

   fir_state_e                        state;
   fir_state_e                        state_nxt;
   logic [KWidth-1:0]                 k;
   logic [0:TapsNum-1][DataWidth-1:0] snap;
   logic                              accept;
   logic                              mul_en;
   logic                              acc_en;
   logic                              out_en;
   logic [DataWidth-1:0]              tap_sel;
   logic [CoefWidth-1:0]              coef_sel;

   assign accept   = in_valid & ready;
   assign tap_sel  = snap[k];
   assign coef_sel = coefs[k];

   // The first MULT edge only loads the product; accumulation starts one edge
   // later and the last product is folded in by the output adder in DRAIN.
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      mul_en    = 1'b0;
      acc_en    = 1'b0;
      out_en    = 1'b0;
      unique case (state)
         IDLE: begin
            ready = 1'b1;
            if (in_valid) begin
               state_nxt = MULT;
            end
         end
         MULT: begin
            mul_en = 1'b1;
            acc_en = (k != '0);
            if (k == KLast) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            out_en    = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         snap      <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         out_valid <= out_en;
         if (accept) begin
            snap <= taps;
            k    <= '0;
         end else if (mul_en) begin
            k <= k + KWidth'(1);
         end
      end
   end

   fir_filter_mac_unit #(
      .DataWidth (DataWidth),
      .CoefWidth (CoefWidth),
      .OutWidth  (OutWidth)
   ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept),
      .mul_en (mul_en),
      .acc_en (acc_en),
      .out_en (out_en),
      .sample (tap_sel),
      .coef   (coef_sel),
      .dout   (dout)
   );

endmodule

// File: tb/tb_fir_filter_serial_mac.sv
// Scoreboard bench for fir_filter_serial_mac with TapsNum = 4, 10 and 1.
module tb_fir_filter_serial_mac;

   typedef struct {
      longint val;
      int     cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic             iv4 = 1'b0, rdy4, ov4;
   logic [0:3][15:0] taps4 = '0, coefs4 = '0;
   logic [33:0]      dout4;

   logic             iv10 = 1'b0, rdy10, ov10;
   logic [0:9][15:0] taps10 = '0, coefs10 = '0;
   logic [35:0]      dout10;

   logic             iv1 = 1'b0, rdy1, ov1;
   logic [0:0][15:0] taps1 = '0, coefs1 = '0;
   logic [31:0]      dout1;

   fir_filter_serial_mac #(.DataWidth(16), .CoefWidth(16), .TapsNum(4)) u4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .ready(rdy4), .taps(taps4),
      .coefs(coefs4), .out_valid(ov4), .dout(dout4));

   fir_filter_serial_mac #(.DataWidth(16), .CoefWidth(16), .TapsNum(10)) u10 (
      .clk(clk), .rst(rst), .in_valid(iv10), .ready(rdy10), .taps(taps10),
      .coefs(coefs10), .out_valid(ov10), .dout(dout10));

   fir_filter_serial_mac #(.DataWidth(16), .CoefWidth(16), .TapsNum(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .ready(rdy1), .taps(taps1),
      .coefs(coefs1), .out_valid(ov1), .dout(dout1));

   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   bit     done = 1'b0;
   longint exp4 = 0, exp10 = 0, exp1 = 0;
   longint last4 = 0, last10 = 0, last1 = 0;
   int     busy4 = 0, busy10 = 0, busy1 = 0;
   exp_t   q4[$], q10[$], q1[$];
   int     vt[10];
   int     vc[10];

   always @(posedge clk) cyc <= cyc + 1;

   // Reference handshake: busy for TapsNum+1 cycles after each accept, result
   // expected TapsNum+1 edges after the accept edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         busy4 = 0; busy10 = 0; busy1 = 0;
         q4.delete(); q10.delete(); q1.delete();
      end else begin
         if (busy4 == 0 && iv4) begin
            q4.push_back(exp_t'{val: exp4, cyc: cyc + 6});
            busy4 = 5;
         end else if (busy4 > 0) busy4--;
         if (busy10 == 0 && iv10) begin
            q10.push_back(exp_t'{val: exp10, cyc: cyc + 12});
            busy10 = 11;
         end else if (busy10 > 0) busy10--;
         if (busy1 == 0 && iv1) begin
            q1.push_back(exp_t'{val: exp1, cyc: cyc + 3});
            busy1 = 2;
         end else if (busy1 > 0) busy1--;
      end
   end

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic score(input string nm, input logic rdy, input int busy,
                        input logic ov, input longint act,
                        ref exp_t q[$], ref longint last);
      exp_t e;
      chk({nm, "_ready"}, longint'(rdy), longint'(busy == 0));
      if (ov) begin
         if (q.size() == 0) begin
            chk({nm, "_out_valid"}, longint'(ov), 0);
         end else begin
            e = q.pop_front();
            chk({nm, "_latency"}, longint'(cyc), longint'(e.cyc));
            chk({nm, "_dout"}, act, e.val);
            last = e.val;
         end
      end else begin
         if (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            chk({nm, "_out_valid"}, longint'(ov), 1);
         end
         chk({nm, "_dout_hold"}, act, last);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         last4 = 0; last10 = 0; last1 = 0;
      end
      score("u4",  rdy4,  busy4,  ov4,  longint'($signed(dout4)),  q4,  last4);
      score("u10", rdy10, busy10, ov10, longint'($signed(dout10)), q10, last10);
      score("u1",  rdy1,  busy1,  ov1,  longint'($signed(dout1)),  q1,  last1);
      if (done) begin
         chk("u4_drained",  longint'(q4.size()),  0);
         chk("u10_drained", longint'(q10.size()), 0);
         chk("u1_drained",  longint'(q1.size()),  0);
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   task automatic send(input int which, input longint e, input bit scramble);
      @(negedge clk);
      case (which)
         4: begin
            for (int i = 0; i < 4; i++) begin
               taps4[i] = 16'(vt[i]); coefs4[i] = 16'(vc[i]);
            end
            exp4 = e; iv4 = 1'b1;
         end
         10: begin
            for (int i = 0; i < 10; i++) begin
               taps10[i] = 16'(vt[i]); coefs10[i] = 16'(vc[i]);
            end
            exp10 = e; iv10 = 1'b1;
         end
         default: begin
            taps1[0] = 16'(vt[0]); coefs1[0] = 16'(vc[0]);
            exp1 = e; iv1 = 1'b1;
         end
      endcase
      @(negedge clk);
      iv4 = 1'b0; iv10 = 1'b0; iv1 = 1'b0;
      for (int n = 0; n < which + 2; n++) begin
         if (scramble)
            for (int i = 0; i < 4; i++) taps4[i] = 16'($urandom);
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;

      vt = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0};  vc = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
      send(4, 10, 1'b0);
      vt = '{10, -20, 30, -40, 0, 0, 0, 0, 0, 0};  vc = '{2, -3, 5, -7, 0, 0, 0, 0, 0, 0};
      send(4, 510, 1'b0);
      vt = '{default: -32768};  vc = '{default: 32767};
      send(4, -64'sd4294836224, 1'b0);
      vt = '{100, 0, -1, 7, 0, 0, 0, 0, 0, 0};  vc = '{default: -1};
      send(4, -106, 1'b0);
      vt = '{5, 6, 7, 8, 0, 0, 0, 0, 0, 0};  vc = '{default: 1};
      send(4, 26, 1'b1);

      // Held in_valid with a fresh vector every cycle: taps {i,2i,-i,1} . {1,2,3,4} = 2i+4
      @(negedge clk);
      for (int i = 0; i < 4; i++) coefs4[i] = 16'(i + 1);
      iv4 = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         taps4[0] = 16'(i); taps4[1] = 16'(2 * i); taps4[2] = 16'(-i); taps4[3] = 16'd1;
         exp4 = longint'(2 * i + 4);
         @(negedge clk);
      end
      iv4 = 1'b0;
      repeat (8) @(negedge clk);

      vt = '{default: -32768};  vc = '{default: -32768};
      send(10, 64'sd10737418240, 1'b0);
      vt = '{default: 32767};  vc = '{default: -32768};
      send(10, -64'sd10737090560, 1'b0);
      vt = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};  vc = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
      send(10, 220, 1'b0);

      vt = '{default: 0};  vt[0] = 7;  vc = '{default: 0};  vc[0] = -3;
      send(1, -21, 1'b0);
      vt[0] = -32768;  vc[0] = -32768;
      send(1, 64'sd1073741824, 1'b0);

      // Reset while k=2 (two MULT edges after accept), asserted between edges
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin taps4[i] = 16'd9; coefs4[i] = 16'd1; end
      exp4 = 36; iv4 = 1'b1;
      @(posedge clk);
      #1 iv4 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      vt = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0};  vc = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
      send(4, 10, 1'b0);

      repeat (4) @(negedge clk);
      done = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
